// File: rtl/pipe_slice_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_slice_pkg                                             |
// | Description : Shared definitions for the pipeline stage slice: mode      |
// |               selectors, slice state encoding and stage payload widths.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pipe_slice_pkg;

    // Slice operating modes
    localparam int unsigned PIPE_MODE_REG  = 0;   // single entry, combinational ready
    localparam int unsigned PIPE_MODE_SKID = 1;   // main + skid entry, registered ready

    // Slice state; the encoding doubles as the occupancy count
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Per-stage bus widths used to size the stage payload vectors
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned OPINFO_W = 8;
    localparam int unsigned ALU_W    = 4;
    localparam int unsigned BRANCH_W = 3;
    localparam int unsigned SYS_W    = 3;
    localparam int unsigned REG_W    = 15;  // rs1, rs2, rd indices
    localparam int unsigned IMM_W    = 32;
    localparam int unsigned MASK_W   = 4;

    // Packed payload widths for the stage-pair wrappers
    localparam int unsigned IF_ID_W = INSTR_W + PC_W;
    localparam int unsigned ID_EX_W = OPINFO_W + ALU_W + BRANCH_W + SYS_W
                                    + REG_W + IMM_W + MASK_W + PC_W;

endpackage : pipe_slice_pkg
`default_nettype wire

// File: rtl/pipe_slice_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_slice_ctrl                                            |
// | Description : Valid/state FSM of the pipeline slice. Generates upstream  |
// |               ready, downstream valid, occupancy, flush handling and the |
// |               load strobes for the data registers held in the parent.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_slice_ctrl
    import pipe_slice_pkg::*;
#(
    parameter int unsigned MODE     = PIPE_MODE_REG,
    parameter bit          FLUSH_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    input  logic       out_ready_i,
    input  logic       flush_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [1:0] occ_o,
    output logic       load_main_o,
    output logic       main_from_skid_o,
    output logic       load_skid_o
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_flush;
    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_accept;
    logic       w_emit;

    generate
        if (FLUSH_EN) begin : g_flush_on
            assign w_flush = flush_i;
        end else begin : g_flush_off
            logic w_flush_unused;
            assign w_flush_unused = flush_i;
            assign w_flush        = 1'b0;
        end
    endgenerate

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = in_valid_i && w_in_ready;
    assign w_emit      = w_out_valid && out_ready_i;

    // Upstream ready: registered in skid mode, combinational in register mode
    generate
        if (MODE == PIPE_MODE_SKID) begin : g_ready_reg
            logic r_in_ready;
            // Ready flop tracks "next state is not TWO" so it never depends on out_ready_i
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != ST_TWO);
                end
            end
            assign w_in_ready = r_in_ready;
        end else begin : g_ready_comb
            assign w_in_ready = (r_state == ST_EMPTY) || out_ready_i;
        end
    endgenerate

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every accept/emit update
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = ST_EMPTY;
        end else if (MODE == PIPE_MODE_SKID) begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_emit) begin
                        w_state_nxt = ST_TWO;
                    end else if (!w_accept && w_emit) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO:   if (w_emit) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end else begin
            if (w_accept) begin
                w_state_nxt = ST_ONE;
            end else if (w_emit) begin
                w_state_nxt = ST_EMPTY;
            end
        end
    end

    // Outputs and data-register load strobes; flushed payloads are never loaded
    always_comb begin
        in_ready_o       = w_in_ready;
        out_valid_o      = w_out_valid;
        occ_o            = r_state;
        load_main_o      = 1'b0;
        load_skid_o      = 1'b0;
        main_from_skid_o = 1'b0;
        if (MODE == PIPE_MODE_SKID) begin
            // In TWO no accept is possible, so main only ever refills from skid
            main_from_skid_o = (r_state == ST_TWO);
            if (!w_flush) begin
                load_main_o = (w_accept && ((r_state != ST_ONE) || w_emit))
                           || ((r_state == ST_TWO) && w_emit);
                load_skid_o = w_accept && (r_state == ST_ONE) && !w_emit;
            end
        end else begin
            load_main_o = w_accept && !w_flush;
        end
    end

endmodule : pipe_slice_ctrl
`default_nettype wire

// File: rtl/pipe_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_slice                                                 |
// | Description : Parametrised valid/ready pipeline stage register with      |
// |               single-entry or 2-entry skid mode, flush and occupancy.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_slice
    import pipe_slice_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MODE     = PIPE_MODE_REG,
    parameter bit          FLUSH_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);

    logic              w_load_main;
    logic              w_main_from_skid;
    logic              w_load_skid;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    pipe_slice_ctrl #(
        .MODE     (MODE),
        .FLUSH_EN (FLUSH_EN)
    ) u_ctrl (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .in_valid_i       (in_valid_i),
        .out_ready_i      (out_ready_i),
        .flush_i          (flush_i),
        .in_ready_o       (in_ready_o),
        .out_valid_o      (out_valid_o),
        .occ_o            (occ_o),
        .load_main_o      (w_load_main),
        .main_from_skid_o (w_main_from_skid),
        .load_skid_o      (w_load_skid)
    );

    // Main entry: always the head of the queue and the downstream payload
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_main <= '0;
        end else if (w_load_main) begin
            r_main <= w_main_from_skid ? r_skid : in_data_i;
        end
    end

    // Skid entry: catches the payload accepted while main is stalled (stays 0 in register mode)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_skid <= '0;
        end else if (w_load_skid) begin
            r_skid <= in_data_i;
        end
    end

    assign out_data_o = r_main;

endmodule : pipe_slice
`default_nettype wire
